// File: rtl/eq_gain_scheduler.sv
// Band-gain command sequencer: queues host gain writes and applies them only on qualified frame boundaries.
// Build option EQ_GAIN_RAMP_EN: defined steps a gain by one per frame; undefined loads the target in one frame.
module eq_gain_scheduler #(
    parameter int NUMBER_OF_FILTERS = 8,
    parameter int GAIN_BITS         = 2,
    parameter int DEFAULT_GAIN      = 1,
    parameter int FIFO_DEPTH        = 4,
    parameter int BAND_BITS         = $clog2(NUMBER_OF_FILTERS)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clk_enable,
    input  logic                                   frame_strobe,
    input  logic                                   eq_enable,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic [BAND_BITS-1:0]                   cfg_band,
    input  logic [GAIN_BITS-1:0]                   cfg_gain,
    output logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] amplifier_gains,
    output logic                                   amplifier_enable,
    output logic                                   busy,
    output logic                                   gain_done,
    output logic                                   cfg_error
);
    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam logic [CNT_BITS-1:0]  FULL_COUNT = CNT_BITS'(FIFO_DEPTH);
    localparam logic [GAIN_BITS-1:0] RESET_GAIN = GAIN_BITS'(DEFAULT_GAIN);
    localparam logic [31:0]          BAND_LIMIT = 32'(NUMBER_OF_FILTERS);

    typedef enum logic [1:0] {IDLE, FETCH, RAMP, DONE} state_t;

    state_t                         state;
    logic [BAND_BITS+GAIN_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]            wr_ptr;
    logic [PTR_BITS-1:0]            rd_ptr;
    logic [CNT_BITS-1:0]            count;
    logic [CNT_BITS-1:0]            count_next;
    logic                           ready_q;
    logic                           push;
    logic                           pop;
    logic                           frame_event;
    logic                           band_valid;
    logic [BAND_BITS-1:0]           cmd_band;
    logic [GAIN_BITS-1:0]           cmd_gain;
    logic [GAIN_BITS-1:0]           cur_gain;
    logic [GAIN_BITS-1:0]           step_gain;
    logic [GAIN_BITS-1:0]           gain_q [NUMBER_OF_FILTERS];
    logic                           amp_en_q;
    logic                           gain_done_q;
    logic                           cfg_error_q;

    always_comb begin
        frame_event = frame_strobe && clk_enable;
        push        = cfg_valid && ready_q;
        pop         = (state == IDLE) && (count != '0);
        count_next  = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
        band_valid = {{(32-BAND_BITS){1'b0}}, cmd_band} < BAND_LIMIT;
        // Mux by comparison so an out-of-range band never indexes past the gain array.
        cur_gain = '0;
        for (int unsigned i = 0; i < NUMBER_OF_FILTERS; i++) begin
            if (cmd_band == BAND_BITS'(i)) begin
                cur_gain = gain_q[i];
            end
        end
`ifdef EQ_GAIN_RAMP_EN
        step_gain = (cur_gain < cmd_gain) ? cur_gain + 1'b1 : cur_gain - 1'b1;
`else
        step_gain = cmd_gain;
`endif
        amplifier_gains = '0;
        for (int unsigned i = 0; i < NUMBER_OF_FILTERS; i++) begin
            amplifier_gains[i*GAIN_BITS +: GAIN_BITS] = gain_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cfg_band, cfg_gain};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ready_q     <= 1'b0;
            cmd_band    <= '0;
            cmd_gain    <= '0;
            amp_en_q    <= 1'b0;
            gain_done_q <= 1'b0;
            cfg_error_q <= 1'b0;
            for (int unsigned i = 0; i < NUMBER_OF_FILTERS; i++) begin
                gain_q[i] <= RESET_GAIN;
            end
        end else begin
            count       <= count_next;
            ready_q     <= (count_next != FULL_COUNT);
            gain_done_q <= 1'b0;
            cfg_error_q <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (frame_event) begin
                amp_en_q <= eq_enable;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        {cmd_band, cmd_gain} <= fifo_mem[rd_ptr];
                        rd_ptr               <= rd_ptr + 1'b1;
                        state                <= FETCH;
                    end
                end
                FETCH: begin
                    if (!band_valid) begin
                        cfg_error_q <= 1'b1;
                        state       <= IDLE;
                    end else if (cur_gain == cmd_gain) begin
                        gain_done_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        state <= RAMP;
                    end
                end
                RAMP: begin
                    if (frame_event) begin
                        for (int unsigned i = 0; i < NUMBER_OF_FILTERS; i++) begin
                            if (cmd_band == BAND_BITS'(i)) begin
                                gain_q[i] <= step_gain;
                            end
                        end
                        if (step_gain == cmd_gain) begin
                            gain_done_q <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign cfg_ready        = ready_q;
    assign amplifier_enable = amp_en_q;
    assign gain_done        = gain_done_q;
    assign cfg_error        = cfg_error_q;
    assign busy             = (count != '0) || (state != IDLE);

endmodule

// File: tb/tb_eq_gain_scheduler.sv
// Self-checking bench for eq_gain_scheduler: queue/array reference model compared every cycle plus directed literals.
// Expectations follow EQ_GAIN_RAMP_EN the same way the design does.
module tb_eq_gain_scheduler;
    localparam int NF    = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_enable = 1'b0;
    logic        frame_strobe = 1'b0;
    logic        eq_enable = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [2:0]  cfg_band = '0;
    logic [1:0]  cfg_gain = '0;
    logic        cfg_ready;
    logic [15:0] amplifier_gains;
    logic        amplifier_enable;
    logic        busy;
    logic        gain_done;
    logic        cfg_error;

    logic        cfg_valid6 = 1'b0;
    logic [2:0]  cfg_band6 = '0;
    logic [1:0]  cfg_gain6 = '0;
    logic        cfg_ready6;
    logic [11:0] gains6;
    logic        amp_en6;
    logic        busy6;
    logic        done6;
    logic        err6;

    int passed = 0;
    int total  = 0;

    eq_gain_scheduler #(.NUMBER_OF_FILTERS(8), .GAIN_BITS(2), .DEFAULT_GAIN(1), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .frame_strobe(frame_strobe),
        .eq_enable(eq_enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_band(cfg_band), .cfg_gain(cfg_gain), .amplifier_gains(amplifier_gains),
        .amplifier_enable(amplifier_enable), .busy(busy), .gain_done(gain_done),
        .cfg_error(cfg_error)
    );

    eq_gain_scheduler #(.NUMBER_OF_FILTERS(6), .GAIN_BITS(2), .DEFAULT_GAIN(1), .FIFO_DEPTH(4)) u_dut6 (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .frame_strobe(frame_strobe),
        .eq_enable(eq_enable), .cfg_valid(cfg_valid6), .cfg_ready(cfg_ready6),
        .cfg_band(cfg_band6), .cfg_gain(cfg_gain6), .amplifier_gains(gains6),
        .amplifier_enable(amp_en6), .busy(busy6), .gain_done(done6),
        .cfg_error(err6)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: pending commands in a queue, one active command walked through
    // "just popped -> checked -> moving toward target -> finishing" by the documented rules.
    typedef struct {int band; int gain;} cmd_t;
    cmd_t m_q[$];
    cmd_t act;
    int   m_gain [NF];
    bit   m_ready, m_en, m_done, m_err;
    bit   have_cmd, checked, finishing, model_live;
    bit   fe, push;

    function automatic logic [15:0] packed_model();
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < NF; i++) p[i*2 +: 2] = 2'(m_gain[i]);
        return p;
    endfunction

    always @(posedge clk) begin
        model_live = 1'b1;
        if (rst) begin
            foreach (m_gain[i]) m_gain[i] = 1;
            m_q.delete();
            m_ready = 0; m_en = 0; m_done = 0; m_err = 0;
            have_cmd = 0; checked = 0; finishing = 0;
        end else begin
            fe     = frame_strobe && clk_enable;
            push   = cfg_valid && m_ready;
            m_done = 0;
            m_err  = 0;
            if (fe) m_en = eq_enable;
            if (finishing) begin
                finishing = 0;
                have_cmd  = 0;
            end else if (have_cmd && !checked) begin
                checked = 1;
                if (act.band >= NF) begin
                    m_err    = 1;
                    have_cmd = 0;
                end else if (m_gain[act.band] == act.gain) begin
                    m_done    = 1;
                    finishing = 1;
                end
            end else if (have_cmd) begin
                if (fe) begin
`ifdef EQ_GAIN_RAMP_EN
                    m_gain[act.band] += (act.gain > m_gain[act.band]) ? 1 : -1;
`else
                    m_gain[act.band] = act.gain;
`endif
                    if (m_gain[act.band] == act.gain) begin
                        m_done    = 1;
                        finishing = 1;
                    end
                end
            end else if (m_q.size() != 0) begin
                act      = m_q.pop_front();
                have_cmd = 1;
                checked  = 0;
            end
            if (push) m_q.push_back('{band: int'(cfg_band), gain: int'(cfg_gain)});
            m_ready = m_q.size() < DEPTH;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("gains", amplifier_gains, packed_model());
            check("amp_enable", amplifier_enable, m_en);
            check("cfg_ready", cfg_ready, m_ready);
            check("gain_done", gain_done, m_done);
            check("cfg_error", cfg_error, m_err);
            check("busy", busy, (m_q.size() != 0) || have_cmd);
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe();
        frame_strobe = 1'b1;
        cycles(1);
        frame_strobe = 1'b0;
    endtask

    task automatic wait_accept();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            ok = cfg_ready;
            cycles(1);
        end
        cfg_valid = 1'b0;
        check("accept_timeout", ok, 1);
    endtask

    task automatic send(input logic [2:0] b, input logic [1:0] g);
        cfg_band  = b;
        cfg_gain  = g;
        cfg_valid = 1'b1;
        wait_accept();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int err_pulses;
        bit seen;

        cycles(3);
        check("ready_in_reset", cfg_ready, 0);
        check("gains_reset", amplifier_gains, 16'h5555);
        check("amp_en_reset", amplifier_enable, 0);
        check("busy_reset", busy, 0);
        rst = 1'b0;
        cycles(1);
        check("ready_after_reset", cfg_ready, 1);

        // Unqualified strobes must not move the enable.
        eq_enable  = 1'b1;
        clk_enable = 1'b0;
        strobe(); cycles(2); strobe();
        check("amp_en_unqualified", amplifier_enable, 0);
        clk_enable = 1'b1;
        strobe();
        check("amp_en_qualified", amplifier_enable, 1);

        // Out-of-range band on the six-band instance.
        check("ready6", cfg_ready6, 1);
        cfg_band6 = 3'd7; cfg_gain6 = 2'd3; cfg_valid6 = 1'b1;
        cycles(1);
        cfg_valid6 = 1'b0;
        err_pulses = 0;
        repeat (6) begin
            if (err6) err_pulses++;
            cycles(1);
        end
        check("err6_pulses", err_pulses, 1);
        check("gains6_unchanged", gains6, 12'h555);
        check("busy6_idle", busy6, 0);
        check("done6_low", done6, 0);
        check("amp_en6", amp_en6, 1);

        // Band 3 -> 3 with a strobe every 64 cycles.
        send(3'd3, 2'd3);
        cycles(62);
        strobe();
`ifdef EQ_GAIN_RAMP_EN
        check("b3_step1", amplifier_gains, 16'h5595);
        check("done_not_yet", gain_done, 0);
        cycles(63);
        strobe();
        check("b3_step2", amplifier_gains, 16'h55D5);
        check("done_pulse", gain_done, 1);
        cycles(1);
        check("done_cleared", gain_done, 0);
`else
        check("b3_jump", amplifier_gains, 16'h55D5);
        check("done_pulse", gain_done, 1);
        cycles(1);
        check("done_cleared", gain_done, 0);
        cycles(62);
        strobe();
        check("b3_stable", amplifier_gains, 16'h55D5);
`endif

        // FIFO backpressure: first command parks waiting for a frame, then fill the queue.
        send(3'd1, 2'd3);
        cycles(3);
        check("busy_parked", busy, 1);
        send(3'd2, 2'd2);
        send(3'd4, 2'd0);
        send(3'd5, 2'd2);
        send(3'd6, 2'd1);
        cfg_band = 3'd7; cfg_gain = 2'd3; cfg_valid = 1'b1;
        check("ready_full", cfg_ready, 0);
        cycles(4);
        check("ready_full_held", cfg_ready, 0);
        strobe();
`ifdef EQ_GAIN_RAMP_EN
        cycles(3);
        strobe();
`endif
        wait_accept();
        for (int k = 0; k < 40 && busy; k++) begin
            cycles(3);
            strobe();
        end
        check("fifo_drained", busy, 0);
        check("gains_after_batch", amplifier_gains, 16'hD8ED);

        // Target equal to current gain completes without any frame.
        send(3'd0, 2'd1);
        seen = 1'b0;
        repeat (3) begin
            if (gain_done) seen = 1'b1;
            cycles(1);
        end
        check("equal_done_seen", seen, 1);
        check("equal_gains", amplifier_gains, 16'hD8ED);

        // Reset while a command is active and another is queued.
        send(3'd5, 2'd0);
        send(3'd6, 2'd3);
`ifdef EQ_GAIN_RAMP_EN
        cycles(2);
        strobe();
        check("b5_mid_ramp", amplifier_gains, 16'hD4ED);
`endif
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(1);
        check("gains_after_rst", amplifier_gains, 16'h5555);
        check("busy_after_rst", busy, 0);
        check("amp_en_after_rst", amplifier_enable, 0);
        strobe();
        cycles(2);
        check("queue_lost", amplifier_gains, 16'h5555);

        // Band 2 from 1 to 3: first frame result depends on the ramp option.
        send(3'd2, 2'd3);
        cycles(3);
        strobe();
`ifdef EQ_GAIN_RAMP_EN
        check("b2_first_frame", amplifier_gains, 16'h5565);
`else
        check("b2_first_frame", amplifier_gains, 16'h5575);
`endif
        cycles(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
